// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and constants.
// State encoding, PC increment, default reset PC and memory-wait timeout.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam int          PC_INC       = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_TIMEOUT  = 16;

endpackage

// File: rtl/pc_adder_32bit.sv
// Plain bit_size-wide adder, carry out dropped (wraps).
// Used for PC+4; the branch-target path can reuse it.
module pc_adder_32bit #(
  parameter int bit_size = 32
) (
  input  logic [bit_size-1:0] a,
  input  logic [bit_size-1:0] b,
  output logic [bit_size-1:0] sum
);

  // Truncating add: 0xFFFF_FFFC + 4 wraps to 0.
  always_comb begin
    sum = a + b;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, imem request/ready handshake, registered Instr.
// Optional macro PC_ALIGN_CHECK_EN: trap misaligned NextPC into S_HALT.
module pc_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                 bit_size = 32,
  parameter logic [bit_size-1:0] RESET_PC = bit_size'(DEF_RESET_PC),
  parameter int                 TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bit_size-1:0] NextPC,
  input  logic                Stall,
  output logic                IM_Req,
  output logic [bit_size-1:0] IM_Addr,
  input  logic                IM_Ready,
  input  logic [bit_size-1:0] IM_RData,
  output logic [bit_size-1:0] PC,
  output logic [bit_size-1:0] PC4Out,
  output logic [bit_size-1:0] Instr,
  output logic                InstrValid,
  output logic                FetchTimeout,
  output logic                MisalignErr
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [bit_size-1:0] INC_W = bit_size'(PC_INC);

  fetch_state_e        state_q, state_d;
  logic [bit_size-1:0] pc_q, pc_d;
  logic [bit_size-1:0] instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic                tmo_q, tmo_d;
  logic                req;

`ifdef PC_ALIGN_CHECK_EN
  logic                mis_q, mis_d;
`else
  localparam logic [bit_size-1:0] ALIGN_MASK = ~bit_size'(3);
`endif

  pc_adder_32bit #(
    .bit_size(bit_size)
  ) u_pc4 (
    .a  (pc_q),
    .b  (INC_W),
    .sum(PC4Out)
  );

  // Next-state, handshake and PC-load logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    req     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        req = 1'b1;
        if (IM_Ready) begin
          instr_d = IM_RData;
          valid_d = 1'b1;
          wcnt_d  = '0;
          state_d = S_VALID;
        end else begin
          if (wcnt_q != TMAX) begin
            wcnt_d = wcnt_q + CW'(1);
          end
          if (wcnt_d == TMAX) begin
            tmo_d = 1'b1;
          end
        end
      end
      S_VALID: begin
        if (valid_q && !Stall) begin
          valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
          if (NextPC[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = NextPC;
            state_d = S_REQ;
          end
`else
          pc_d    = NextPC & ALIGN_MASK;
          state_d = S_REQ;
`endif
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign MisalignErr = mis_q;
`else
  assign MisalignErr = 1'b0;
`endif

  assign IM_Req       = req;
  assign IM_Addr      = pc_q;
  assign PC           = pc_q;
  assign Instr        = instr_q;
  assign InstrValid   = valid_q;
  assign FetchTimeout = tmo_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Follows PC_ALIGN_CHECK_EN when the macro is defined for the build.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] NextPC;
  logic        Stall;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ready;
  logic [31:0] IM_RData;
  logic [31:0] PC;
  logic [31:0] PC4Out;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        FetchTimeout;
  logic        MisalignErr;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .NextPC      (NextPC),
    .Stall       (Stall),
    .IM_Req      (IM_Req),
    .IM_Addr     (IM_Addr),
    .IM_Ready    (IM_Ready),
    .IM_RData    (IM_RData),
    .PC          (PC),
    .PC4Out      (PC4Out),
    .Instr       (Instr),
    .InstrValid  (InstrValid),
    .FetchTimeout(FetchTimeout),
    .MisalignErr (MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    NextPC   = '0;
    Stall    = 1'b0;
    IM_Ready = 1'b0;
    IM_RData = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",    PC, 32'h0);
    chk("rst_req",   {31'b0, IM_Req}, 32'h0);
    chk("rst_vld",   {31'b0, InstrValid}, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_tmo",   {31'b0, FetchTimeout}, 32'h0);
    chk("rst_mis",   {31'b0, MisalignErr}, 32'h0);
    chk("rst_pc4",   PC4Out, 32'h4);

    // idle cycle, then zero-wait streaming
    rst      = 1'b1;
    IM_Ready = 1'b1;
    chk("idle_req", {31'b0, IM_Req}, 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("zw_req%0d", k),  {31'b0, IM_Req}, 32'h1);
      chk($sformatf("zw_addr%0d", k), IM_Addr, 32'(4 * k));
      chk($sformatf("zw_pc%0d", k),   PC, 32'(4 * k));
      chk($sformatf("zw_nv%0d", k),   {31'b0, InstrValid}, 32'h0);
      IM_RData = 32'h1111_0000 + 32'(k);
      NextPC   = 32'(4 * k + 4);
      step();
      chk($sformatf("zw_vld%0d", k),  {31'b0, InstrValid}, 32'h1);
      chk($sformatf("zw_ins%0d", k),  Instr, 32'h1111_0000 + 32'(k));
      chk($sformatf("zw_nreq%0d", k), {31'b0, IM_Req}, 32'h0);
      step();
    end

    // 3 wait states at PC=0x10
    IM_Ready = 1'b0;
    chk("ws_addr0", IM_Addr, 32'h10);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("ws_req%0d", i),  {31'b0, IM_Req}, 32'h1);
      chk($sformatf("ws_addr%0d", i), IM_Addr, 32'h10);
      chk($sformatf("ws_nv%0d", i),   {31'b0, InstrValid}, 32'h0);
    end
    IM_Ready = 1'b1;
    IM_RData = 32'h2001_0005;
    step();
    chk("ws_vld", {31'b0, InstrValid}, 32'h1);
    chk("ws_ins", Instr, 32'h2001_0005);

    // stall with toggling NextPC, memory noise ignored
    Stall    = 1'b1;
    IM_RData = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      NextPC = (i % 2 == 1) ? 32'h80 : 32'h40;
      step();
      chk($sformatf("st_pc%0d", i),  PC, 32'h10);
      chk($sformatf("st_ins%0d", i), Instr, 32'h2001_0005);
      chk($sformatf("st_vld%0d", i), {31'b0, InstrValid}, 32'h1);
      chk($sformatf("st_req%0d", i), {31'b0, IM_Req}, 32'h0);
    end
    Stall  = 1'b0;
    NextPC = 32'h80;
    step();
    chk("st_acc_pc",  PC, 32'h80);
    chk("st_acc_vld", {31'b0, InstrValid}, 32'h0);
    chk("st_acc_req", {31'b0, IM_Req}, 32'h1);

    // timeout: 20 wait cycles
    IM_Ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("to_flag%0d", i), {31'b0, FetchTimeout},
          (i >= 16) ? 32'h1 : 32'h0);
      chk($sformatf("to_req%0d", i), {31'b0, IM_Req}, 32'h1);
    end
    IM_Ready = 1'b1;
    IM_RData = 32'h0000_0013;
    step();
    chk("to_vld",    {31'b0, InstrValid}, 32'h1);
    chk("to_sticky", {31'b0, FetchTimeout}, 32'h1);

    // PC wrap
    IM_Ready = 1'b0;
    NextPC   = 32'hFFFF_FFFC;
    step();
    chk("wr_pc",  PC, 32'hFFFF_FFFC);
    chk("wr_pc4", PC4Out, 32'h0);
    IM_Ready = 1'b1;
    step();
    NextPC = 32'h0;
    step();
    chk("wr_acc", PC, 32'h0);
    chk("wr_tmo", {31'b0, FetchTimeout}, 32'h1);

    // misaligned accept
    step();
    chk("ma_vld", {31'b0, InstrValid}, 32'h1);
    NextPC = 32'h0000_0102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("ma_err", {31'b0, MisalignErr}, 32'h1);
    chk("ma_pc",  PC, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ma_halt_req%0d", i), {31'b0, IM_Req}, 32'h0);
      chk($sformatf("ma_halt_vld%0d", i), {31'b0, InstrValid}, 32'h0);
      step();
    end
    chk("ma_halt_pc", PC, 32'h0);
`else
    chk("ma_err", {31'b0, MisalignErr}, 32'h0);
    chk("ma_pc",  PC, 32'h0000_0100);
    chk("ma_req", {31'b0, IM_Req}, 32'h1);
    IM_RData = 32'h0000_0033;
    step();
    chk("ma_cont_vld", {31'b0, InstrValid}, 32'h1);
    chk("ma_cont_ins", Instr, 32'h0000_0033);
`endif

    // restart, set timeout at PC=0x20, then async reset mid-S_REQ
    rst = 1'b0;
    #2;
    rst      = 1'b1;
    IM_Ready = 1'b1;
    IM_RData = 32'h0000_0077;
    NextPC   = 32'h20;
    step();
    chk("ar_req0", {31'b0, IM_Req}, 32'h1);
    step();
    step();
    chk("ar_pc0", PC, 32'h20);
    IM_Ready = 1'b0;
    repeat (17) step();
    chk("ar_tmo_pre", {31'b0, FetchTimeout}, 32'h1);
    chk("ar_req_pre", {31'b0, IM_Req}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req",   {31'b0, IM_Req}, 32'h0);
    chk("ar_pc",    PC, 32'h0);
    chk("ar_addr",  IM_Addr, 32'h0);
    chk("ar_tmo",   {31'b0, FetchTimeout}, 32'h0);
    chk("ar_vld",   {31'b0, InstrValid}, 32'h0);
    chk("ar_instr", Instr, 32'h0);
    chk("ar_mis",   {31'b0, MisalignErr}, 32'h0);
    IM_Ready = 1'b1;
    IM_RData = 32'hCAFE_F00D;
    step();
    chk("ar_hold_instr", Instr, 32'h0);
    chk("ar_hold_vld",   {31'b0, InstrValid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
